input_regfile_ctrl: RTL and testbench
=====================================

// Module: input_regfile_ctrl
// PURPOSE
//  Sequencer for the Input_Regfile of one conv layer pass: loads cfg_chunks 8-byte chunks from In_Out_buffer.
//  Then issues cfg_groups tap windows of K cycles each, one per weight group, reusing the same input.
//  Closes each window with a pe_end pulse. Sits between SPU (start/cfg), In_Out_buffer, Mem_Ctrl and PE_Array.
// PARAMETERS
//  BM        8   bytes per loaded chunk (lanes of IR_Data_I*)
//  LANES     16  PE rows fed per tap (IR_Data_O0..Of)
//  RF_DEPTH  256 regfile bytes; cfg_chunks*BM must be <= RF_DEPTH
//  DRAIN_CYC 2   cycles from last tap to pe_end (regfile output reg + PE accumulate)
// PORTS
//  clk_cal         in  1  calc clock
//  rst_cal_n       in  1  synchronous active-low reset
//  start           in  1  1-cycle pulse, accepted only in IDLE
//  cfg_K           in  8  kernel taps per window (1..255), sampled on start
//  cfg_S           in  8  stride, sampled on start
//  cfg_chunks      in  6  chunks to load (1..32, 0 illegal), sampled on start
//  cfg_groups      in  8  weight groups per load (0 illegal), sampled on start
//  ib_req          out 1  chunk request to In_Out_buffer
//  ib_vld          in  1  chunk present this cycle (also drives IR_Data_I_vld)
//  bm_cnt          out 6  index of chunk accepted this cycle (-> Bm_cnt_in)
//  wt_rdy          in  1  Mem_Ctrl has the next group's weights ready
//  tap_vld         out 1  one tap issued (-> Weight_Data_Ovld path)
//  tap_idx         out 8  tap index 0..K-1, 0 when tap_vld=0
//  pe_end          out 1  1-cycle window-end pulse to PE_Array / regfile
//  busy            out 1  high in all states except IDLE
//  done            out 1  1-cycle pulse at pass end
//  err             out 1  sticky illegal-config flag; cleared by next accepted start
// BEHAVIOUR
//  Reset (rst_cal_n=0 at a clk_cal edge):
//   - Enters IDLE from any state, including mid-load or mid-window.
//   - All outputs and counters go to 0; no pe_end or done is emitted for the aborted pass.
//  Config check on start:
//   - Illegal if any of: K==0, chunks==0, groups==0, or K-1+(LANES-1)*S > chunks*BM-1.
//   - Illegal config -> ERR for 1 cycle, then IDLE; err=1 and done pulses in the ERR cycle.
//  FSM IDLE->LOAD->WAIT_WT->TAP->DRAIN->(WAIT_WT | FIN)->IDLE; each transition takes 1 cycle.
//  LOAD:
//   - ib_req=1. Each cycle with ib_vld=1, bm_cnt = current chunk index and the index increments.
//   - Entering LOAD, bm_cnt=0. bm_cnt holds its value when ib_vld=0.
//   - After chunk cfg_chunks-1 is accepted, ib_req drops in the same cycle (combinational on last accept).
//   - Next state is WAIT_WT.
//   - ib_vld outside LOAD is ignored and bm_cnt does not change.
//  WAIT_WT:
//   - tap_vld=0 until wt_rdy=1; then go to TAP.
//  TAP:
//   - tap_vld=1 for exactly K consecutive cycles; tap_idx runs 0..K-1.
//   - The window is atomic: wt_rdy is ignored inside it, because the regfile read pointer resets on any tap_vld gap.
//  DRAIN:
//   - DRAIN_CYC cycles with tap_vld=0. pe_end=1 in the last DRAIN cycle.
//   - Then the group counter increments. Go to WAIT_WT if groups remain, else FIN.
//  FIN: done=1 for 1 cycle, then IDLE.
//  start while busy: ignored and no state change. start and reset in the same cycle: reset wins.
//  Latency: the first tap is issued 1 cycle after WAIT_WT sees wt_rdy=1.
//  Minimum pass length in cycles: 1 + chunks + groups*(1 + K + DRAIN_CYC) + 1.
//  Arithmetic:
//   - Window-bound check is done in 13 bits, unsigned.
//   - Chunk counter is 6 bits; group counter and tap counter are 8 bits. None of them wraps under a legal config.
// CONFIGURATION
//  IRC_PERF_CNT_EN defined:
//   - Adds output perf_stall_cyc [15:0], which counts cycles spent in WAIT_WT with wt_rdy=0.
//   - It also counts LOAD cycles with ib_vld=0.
//   - Cleared on an accepted start; saturates at 16'hFFFF; held after done.
//  IRC_PERF_CNT_EN undefined: no port and no counter; all other behaviour is identical.
// TESTING
//  T1 K=3,S=1,chunks=3,groups=2, ib_vld and wt_rdy tied 1:
//     bm_cnt 0,1,2; then tap_idx 0,1,2 twice; 2 pe_end pulses; done at cycle 1+3+2*(1+3+2)+1=17.
//  T2 ib_vld toggles 1,0,1,0,1 with chunks=3: bm_cnt holds across gaps; exactly 3 increments; ib_req drops with the third accept.
//  T3 wt_rdy low for 5 cycles before group 1: tap_vld=0 in those cycles; then 3 contiguous taps.
//     With IRC_PERF_CNT_EN: perf_stall_cyc=5.
//  T4 K=8,S=2,chunks=4 (7+30=37>31): err=1 and done pulse 1 cycle after start; no ib_req, no tap_vld.
//     A following legal start clears err.
//  T5 reset asserted at tap_idx=1 of group 0: next cycle all outputs are 0 and state is IDLE; no pe_end.
//     A new start runs a full clean pass.
//  T6 start pulsed mid-TAP: ignored; tap sequence and done timing unchanged vs T1.

Source files
------------

// File: rtl/input_regfile_ctrl.sv
// Input_Regfile sequencer: loads cfg_chunks chunks, then runs one K-tap window per weight group.
// Optional stall-cycle counter enabled by defining IRC_PERF_CNT_EN.
module input_regfile_ctrl #(
    parameter int unsigned BM        = 8,
    parameter int unsigned LANES     = 16,
    parameter int unsigned RF_DEPTH  = 256,
    parameter int unsigned DRAIN_CYC = 2
) (
    input  logic        clk_cal,
    input  logic        rst_cal_n,
    input  logic        start,
    input  logic [7:0]  cfg_K,
    input  logic [7:0]  cfg_S,
    input  logic [5:0]  cfg_chunks,
    input  logic [7:0]  cfg_groups,
    output logic        ib_req,
    input  logic        ib_vld,
    output logic [5:0]  bm_cnt,
    input  logic        wt_rdy,
    output logic        tap_vld,
    output logic [7:0]  tap_idx,
    output logic        pe_end,
    output logic        busy,
    output logic        done,
`ifdef IRC_PERF_CNT_EN
    output logic [15:0] perf_stall_cyc,
`endif
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitWt,
        StTap,
        StDrain,
        StFin,
        StErr
    } state_e;

    state_e      state_q;
    logic [5:0]  chunk_cnt_q;
    logic [7:0]  tap_cnt_q;
    logic [7:0]  grp_cnt_q;
    logic [7:0]  drain_cnt_q;
    logic [7:0]  k_q;
    logic [5:0]  chunks_q;
    logic [7:0]  groups_q;
    logic        err_q;

    logic [12:0] win_last;
    logic [12:0] rf_bytes;
    logic [12:0] rf_last;
    logic        cfg_bad;
    logic        last_accept;

    // Last regfile byte touched by the widest lane vs. last byte actually loaded.
    assign win_last = 13'(cfg_K) - 13'd1 + 13'(LANES - 1) * 13'(cfg_S);
    assign rf_bytes = 13'(cfg_chunks) * 13'(BM);
    assign rf_last  = rf_bytes - 13'd1;

    assign cfg_bad = (cfg_K == 8'd0) || (cfg_chunks == 6'd0) || (cfg_groups == 8'd0) ||
                     (win_last > rf_last) || (rf_bytes > 13'(RF_DEPTH));

    assign last_accept = (state_q == StLoad) && ib_vld && (chunk_cnt_q == chunks_q - 6'd1);

    always_ff @(posedge clk_cal) begin
        if (!rst_cal_n) begin
            state_q     <= StIdle;
            chunk_cnt_q <= 6'd0;
            tap_cnt_q   <= 8'd0;
            grp_cnt_q   <= 8'd0;
            drain_cnt_q <= 8'd0;
            k_q         <= 8'd0;
            chunks_q    <= 6'd0;
            groups_q    <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        k_q         <= cfg_K;
                        chunks_q    <= cfg_chunks;
                        groups_q    <= cfg_groups;
                        err_q       <= cfg_bad;
                        chunk_cnt_q <= 6'd0;
                        tap_cnt_q   <= 8'd0;
                        grp_cnt_q   <= 8'd0;
                        drain_cnt_q <= 8'd0;
                        state_q     <= cfg_bad ? StErr : StLoad;
                    end
                end
                StLoad: begin
                    if (ib_vld) begin
                        chunk_cnt_q <= chunk_cnt_q + 6'd1;
                        if (last_accept) begin
                            state_q <= StWaitWt;
                        end
                    end
                end
                StWaitWt: begin
                    if (wt_rdy) begin
                        state_q <= StTap;
                    end
                end
                StTap: begin
                    // Window is atomic: no exit until all K taps are issued.
                    if (tap_cnt_q == k_q - 8'd1) begin
                        tap_cnt_q   <= 8'd0;
                        drain_cnt_q <= 8'd0;
                        state_q     <= StDrain;
                    end else begin
                        tap_cnt_q <= tap_cnt_q + 8'd1;
                    end
                end
                StDrain: begin
                    if (drain_cnt_q == 8'(DRAIN_CYC - 1)) begin
                        drain_cnt_q <= 8'd0;
                        grp_cnt_q   <= grp_cnt_q + 8'd1;
                        state_q     <= (grp_cnt_q == groups_q - 8'd1) ? StFin : StWaitWt;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 8'd1;
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                StErr: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // ib_req drops combinationally on the final accept so no extra chunk is requested.
    assign ib_req  = (state_q == StLoad) && !last_accept;
    assign bm_cnt  = chunk_cnt_q;
    assign tap_vld = (state_q == StTap);
    assign tap_idx = (state_q == StTap) ? tap_cnt_q : 8'd0;
    assign pe_end  = (state_q == StDrain) && (drain_cnt_q == 8'(DRAIN_CYC - 1));
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StFin) || (state_q == StErr);
    assign err     = err_q;

`ifdef IRC_PERF_CNT_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk_cal) begin
        if (!rst_cal_n) begin
            perf_q <= 16'd0;
        end else if ((state_q == StIdle) && start) begin
            perf_q <= 16'd0;
        end else if ((((state_q == StWaitWt) && !wt_rdy) || ((state_q == StLoad) && !ib_vld)) &&
                     (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_stall_cyc = perf_q;
`endif

endmodule

// File: tb/tb_input_regfile_ctrl.sv
// Directed bench for input_regfile_ctrl: per-cycle output capture checked against hand-computed
// cycle numbers (cycle 0 = the cycle start is driven).
module tb_input_regfile_ctrl;

    logic        clk_cal = 1'b0;
    logic        rst_cal_n;
    logic        start;
    logic [7:0]  cfg_K;
    logic [7:0]  cfg_S;
    logic [5:0]  cfg_chunks;
    logic [7:0]  cfg_groups;
    logic        ib_req;
    logic        ib_vld;
    logic [5:0]  bm_cnt;
    logic        wt_rdy;
    logic        tap_vld;
    logic [7:0]  tap_idx;
    logic        pe_end;
    logic        busy;
    logic        done;
    logic        err;
`ifdef IRC_PERF_CNT_EN
    logic [15:0] perf_stall_cyc;
`endif

    int tests = 0;
    int fails = 0;

    localparam int NC = 64;
    localparam int S_REQ = 0, S_BM = 1, S_TV = 2, S_TI = 3, S_PE = 4, S_DN = 5, S_BSY = 6,
                   S_ERR = 7;

    logic [7:0] rec [8][NC];
    bit st_pat  [NC];
    bit ibv_pat [NC];
    bit wrd_pat [NC];
    bit rst_pat [NC];

    input_regfile_ctrl dut (
        .clk_cal        (clk_cal),
        .rst_cal_n      (rst_cal_n),
        .start          (start),
        .cfg_K          (cfg_K),
        .cfg_S          (cfg_S),
        .cfg_chunks     (cfg_chunks),
        .cfg_groups     (cfg_groups),
        .ib_req         (ib_req),
        .ib_vld         (ib_vld),
        .bm_cnt         (bm_cnt),
        .wt_rdy         (wt_rdy),
        .tap_vld        (tap_vld),
        .tap_idx        (tap_idx),
        .pe_end         (pe_end),
        .busy           (busy),
        .done           (done),
`ifdef IRC_PERF_CNT_EN
        .perf_stall_cyc (perf_stall_cyc),
`endif
        .err            (err)
    );

    always #5 clk_cal = ~clk_cal;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_pat();
        for (int c = 0; c < NC; c++) begin
            st_pat[c]  = 1'b0;
            ibv_pat[c] = 1'b1;
            wrd_pat[c] = 1'b1;
            rst_pat[c] = 1'b0;
        end
        st_pat[0] = 1'b1;
    endtask

    task automatic set_cfg(input int k, input int s, input int ch, input int gr);
        cfg_K      = 8'(k);
        cfg_S      = 8'(s);
        cfg_chunks = 6'(ch);
        cfg_groups = 8'(gr);
    endtask

    // Entered and left just after a rising edge; inputs change there, outputs sampled at negedge.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            start     = st_pat[c];
            ib_vld    = ibv_pat[c];
            wt_rdy    = wrd_pat[c];
            rst_cal_n = !rst_pat[c];
            @(negedge clk_cal);
            rec[S_REQ][c] = {7'd0, ib_req};
            rec[S_BM][c]  = {2'd0, bm_cnt};
            rec[S_TV][c]  = {7'd0, tap_vld};
            rec[S_TI][c]  = tap_idx;
            rec[S_PE][c]  = {7'd0, pe_end};
            rec[S_DN][c]  = {7'd0, done};
            rec[S_BSY][c] = {7'd0, busy};
            rec[S_ERR][c] = {7'd0, err};
            @(posedge clk_cal);
            #1;
        end
        start     = 1'b0;
        ib_vld    = 1'b0;
        wt_rdy    = 1'b0;
        rst_cal_n = 1'b1;
    endtask

    function automatic int cnt_hi(input int s, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (rec[s][c] != 8'd0) n++;
        return n;
    endfunction

    function automatic int first_hi(input int s, input int n);
        for (int c = 0; c < n; c++) if (rec[s][c] != 8'd0) return c;
        return -1;
    endfunction

    initial begin
        rst_cal_n = 1'b0;
        start     = 1'b0;
        ib_vld    = 1'b0;
        wt_rdy    = 1'b0;
        set_cfg(3, 1, 3, 2);
        repeat (2) @(posedge clk_cal);
        #1;
        @(negedge clk_cal);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_outs", {16'd0, ib_req, tap_vld, pe_end, done, err, tap_idx, 5'd0}, 32'd0);
        chk("rst_bm_cnt", {26'd0, bm_cnt}, 32'd0);
        @(posedge clk_cal);
        #1;
        rst_cal_n = 1'b1;

        // T1: basic pass, all handshakes tied high.
        clear_pat();
        set_cfg(3, 1, 3, 2);
        run(20);
        chk("t1_bm_c1", rec[S_BM][1], 0);
        chk("t1_bm_c2", rec[S_BM][2], 1);
        chk("t1_bm_c3", rec[S_BM][3], 2);
        chk("t1_req_c1", rec[S_REQ][1], 1);
        chk("t1_req_last", rec[S_REQ][3], 0);
        chk("t1_req_cnt", cnt_hi(S_REQ, 0, 19), 2);
        chk("t1_first_tap", first_hi(S_TV, 20), 5);
        chk("t1_tap_cnt", cnt_hi(S_TV, 0, 19), 6);
        chk("t1_idx_g0", {rec[S_TI][5], rec[S_TI][6], rec[S_TI][7]}, 32'h000102);
        chk("t1_idx_g1", {rec[S_TI][11], rec[S_TI][12], rec[S_TI][13]}, 32'h000102);
        chk("t1_pe_pos", {rec[S_PE][9], rec[S_PE][15]}, 32'h0101);
        chk("t1_pe_cnt", cnt_hi(S_PE, 0, 19), 2);
        chk("t1_done_at", first_hi(S_DN, 20), 16);
        chk("t1_done_cnt", cnt_hi(S_DN, 0, 19), 1);
        chk("t1_busy_end", {rec[S_BSY][16], rec[S_BSY][17]}, 32'h0100);
        chk("t1_err", cnt_hi(S_ERR, 0, 19), 0);

        // T2: gapped chunk delivery.
        clear_pat();
        set_cfg(3, 1, 3, 1);
        ibv_pat[2] = 1'b0;
        ibv_pat[4] = 1'b0;
        run(16);
        chk("t2_bm_c2", rec[S_BM][2], 1);
        chk("t2_bm_c3", rec[S_BM][3], 1);
        chk("t2_bm_c4", rec[S_BM][4], 2);
        chk("t2_bm_c5", rec[S_BM][5], 2);
        chk("t2_req_c4", rec[S_REQ][4], 1);
        chk("t2_req_c5", rec[S_REQ][5], 0);
        chk("t2_first_tap", first_hi(S_TV, 16), 7);
        chk("t2_done_at", first_hi(S_DN, 16), 12);
`ifdef IRC_PERF_CNT_EN
        chk("t2_perf", {16'd0, perf_stall_cyc}, 2);
`endif

        // T3: weights late for group 1.
        clear_pat();
        set_cfg(3, 1, 3, 2);
        for (int c = 10; c < 15; c++) wrd_pat[c] = 1'b0;
        run(26);
        chk("t3_no_tap_stall", cnt_hi(S_TV, 8, 15), 0);
        chk("t3_tap_g1", cnt_hi(S_TV, 16, 18), 3);
        chk("t3_idx_g1", {rec[S_TI][16], rec[S_TI][17], rec[S_TI][18]}, 32'h000102);
        chk("t3_pe_g1", rec[S_PE][20], 1);
        chk("t3_done_at", first_hi(S_DN, 26), 21);
`ifdef IRC_PERF_CNT_EN
        chk("t3_perf", {16'd0, perf_stall_cyc}, 5);
`endif

        // T4: window overruns loaded bytes (7+30 > 31).
        clear_pat();
        set_cfg(8, 2, 4, 1);
        run(6);
        chk("t4_err_done_c1", {rec[S_ERR][1], rec[S_DN][1], rec[S_BSY][1]}, 32'h010101);
        chk("t4_c2", {rec[S_ERR][2], rec[S_DN][2], rec[S_BSY][2]}, 32'h010000);
        chk("t4_no_req", cnt_hi(S_REQ, 0, 5), 0);
        chk("t4_no_tap", cnt_hi(S_TV, 0, 5), 0);
        clear_pat();
        set_cfg(0, 1, 3, 1);
        run(4);
        chk("t4_k0_err", {rec[S_ERR][1], rec[S_DN][1]}, 32'h0101);
        clear_pat();
        set_cfg(3, 1, 3, 2);
        run(20);
        chk("t4_err_cleared", rec[S_ERR][1], 0);
        chk("t4_legal_done", first_hi(S_DN, 20), 16);

        // T5: reset mid-window, then start coincident with reset, then a clean pass.
        clear_pat();
        set_cfg(3, 1, 3, 2);
        rst_pat[6] = 1'b1;
        run(14);
        chk("t5_idx_before", rec[S_TI][6], 1);
        chk("t5_after_rst", {rec[S_BSY][7], rec[S_TV][7], rec[S_TI][7], rec[S_REQ][7]}, 0);
        chk("t5_after_rst2", {rec[S_PE][7], rec[S_DN][7], rec[S_ERR][7], rec[S_BM][7]}, 0);
        chk("t5_no_pe", cnt_hi(S_PE, 0, 13), 0);
        chk("t5_no_done", cnt_hi(S_DN, 0, 13), 0);
        clear_pat();
        rst_pat[0] = 1'b1;
        run(3);
        chk("t5_rst_wins", cnt_hi(S_BSY, 0, 2), 0);
        clear_pat();
        run(20);
        chk("t5_clean_taps", cnt_hi(S_TV, 0, 19), 6);
        chk("t5_clean_pe", cnt_hi(S_PE, 0, 19), 2);
        chk("t5_clean_done", first_hi(S_DN, 20), 16);

        // T6: start pulses while busy are ignored.
        clear_pat();
        st_pat[6]  = 1'b1;
        st_pat[12] = 1'b1;
        run(20);
        chk("t6_first_tap", first_hi(S_TV, 20), 5);
        chk("t6_tap_cnt", cnt_hi(S_TV, 0, 19), 6);
        chk("t6_idx_g0", {rec[S_TI][5], rec[S_TI][6], rec[S_TI][7]}, 32'h000102);
        chk("t6_idx_g1", {rec[S_TI][11], rec[S_TI][12], rec[S_TI][13]}, 32'h000102);
        chk("t6_pe_pos", {rec[S_PE][9], rec[S_PE][15]}, 32'h0101);
        chk("t6_done_at", first_hi(S_DN, 20), 16);
        chk("t6_idle_after", rec[S_BSY][17], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
